ex_operand_stage: RTL and testbench

ID/EX pipeline register and EX-stage operand network of the pipelined MIPS core. Each cycle it holds one decoded instruction. It resolves the ALU source operands by forwarding from the EX/MEM and MEM/WB stages. It drives the ALU's `a`, `b`, `af` and `i` inputs directly, and inserts a one-cycle bubble on a load-use hazard. Valid/ready handshakes on both sides support stall and flush.

---
 rtl/ex_operand_stage.sv | 138 +++++++++++++
 tb/tb_ex_operand_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX register with EX-stage operand forwarding and load-use bubble insertion.
// Latency: instruction accepted at edge k drives alu_* in cycle k+1; forwarding is combinational.
// Backpressure: holds all fields while out_ready=0 or on a load-use hazard; in_ready drops accordingly.
module ex_operand_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_rs_val,
  input  logic [N-1:0] in_rt_val,
  input  logic [4:0]   in_rs,
  input  logic [4:0]   in_rt,
  input  logic [4:0]   in_rd,
  input  logic [N-1:0] in_imm,
  input  logic         in_use_imm,
  input  logic [3:0]   in_af,
  input  logic         in_i,
  input  logic         in_we,
  input  logic         in_is_load,
  input  logic         exmem_we,
  input  logic         exmem_is_load,
  input  logic [4:0]   exmem_rd,
  input  logic [N-1:0] exmem_res,
  input  logic         memwb_we,
  input  logic [4:0]   memwb_rd,
  input  logic [N-1:0] memwb_res,
  input  logic         flush,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_af,
  output logic         alu_i,
  output logic [N-1:0] store_data,
  output logic [4:0]   out_rd,
  output logic         out_we,
  output logic         out_is_load
);

  typedef struct packed {
    logic [N-1:0] rs_val;
    logic [N-1:0] rt_val;
    logic [N-1:0] imm;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic         use_imm;
    logic [3:0]   af;
    logic         i;
    logic         we;
    logic         is_load;
  } fields_t;

  fields_t      q;
  fields_t      d;
  logic         valid_q;
  logic         hazard;
  logic         capture;
  logic [N-1:0] fwd_rs;
  logic [N-1:0] fwd_rt;

  // A load still in EX/MEM cannot supply its data yet; rt is checked even for
  // immediate forms, which may cost a spare bubble but never a wrong operand.
  always_comb begin
    hazard = valid_q && exmem_we && exmem_is_load && (exmem_rd != 5'd0) &&
             ((exmem_rd == q.rs) || (exmem_rd == q.rt));
  end

  // Handshake: a bubble blocks both issue and acceptance.
  always_comb begin
    out_valid = valid_q && !hazard;
    in_ready  = !valid_q || (out_ready && !hazard);
    capture   = in_valid && in_ready && !flush;
  end

  // Operand rs: youngest producer wins; register 0 is never forwarded.
  always_comb begin
    fwd_rs = q.rs_val;
    if (exmem_we && (exmem_rd == q.rs) && (q.rs != 5'd0) && !exmem_is_load)
      fwd_rs = exmem_res;
    else if (memwb_we && (memwb_rd == q.rs) && (q.rs != 5'd0))
      fwd_rs = memwb_res;
  end

  // Operand rt: same priority as rs.
  always_comb begin
    fwd_rt = q.rt_val;
    if (exmem_we && (exmem_rd == q.rt) && (q.rt != 5'd0) && !exmem_is_load)
      fwd_rt = exmem_res;
    else if (memwb_we && (memwb_rd == q.rt) && (q.rt != 5'd0))
      fwd_rt = memwb_res;
  end

  // Pack the incoming decode fields.
  always_comb begin
    d.rs_val  = in_rs_val;
    d.rt_val  = in_rt_val;
    d.imm     = in_imm;
    d.rs      = in_rs;
    d.rt      = in_rt;
    d.rd      = in_rd;
    d.use_imm = in_use_imm;
    d.af      = in_af;
    d.i       = in_i;
    d.we      = in_we;
    d.is_load = in_is_load;
  end

  // Pipeline register: reset beats flush, flush beats capture, drain clears valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      q       <= d;
    end else if (out_valid && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Drive the ALU and downstream register from the held instruction.
  always_comb begin
    alu_a       = fwd_rs;
    alu_b       = q.use_imm ? q.imm : fwd_rt;
    store_data  = fwd_rt;
    alu_af      = q.af;
    alu_i       = q.i;
    out_rd      = q.rd;
    out_we      = q.we && out_valid;
    out_is_load = q.is_load;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage.
// Drives inputs 1ns after the rising edge and samples 1ns later.
// Each scenario task carries its own inline comparisons.
module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_rs_val, in_rt_val, in_imm;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_use_imm, in_i, in_we, in_is_load;
  logic [3:0]  in_af;
  logic        exmem_we, exmem_is_load;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_res;
  logic        memwb_we;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_res;
  logic        flush, out_ready, out_valid;
  logic [31:0] alu_a, alu_b, store_data;
  logic [3:0]  alu_af;
  logic        alu_i;
  logic [4:0]  out_rd;
  logic        out_we, out_is_load;

  int checks = 0;
  int fails  = 0;

  ex_operand_stage #(.N(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_af(in_af),
    .in_i(in_i), .in_we(in_we), .in_is_load(in_is_load),
    .exmem_we(exmem_we), .exmem_is_load(exmem_is_load), .exmem_rd(exmem_rd),
    .exmem_res(exmem_res), .memwb_we(memwb_we), .memwb_rd(memwb_rd),
    .memwb_res(memwb_res), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_af(alu_af),
    .alu_i(alu_i), .store_data(store_data), .out_rd(out_rd), .out_we(out_we),
    .out_is_load(out_is_load)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs_val = 0; in_rt_val = 0; in_imm = 0;
    in_rs = 0; in_rt = 0; in_rd = 0; in_use_imm = 0; in_i = 0;
    in_we = 0; in_is_load = 0; in_af = 0;
    exmem_we = 0; exmem_is_load = 0; exmem_rd = 0; exmem_res = 0;
    memwb_we = 0; memwb_rd = 0; memwb_res = 0; flush = 0;
  endtask

  task automatic offer(input logic [4:0] rs, input logic [31:0] rsv,
                       input logic [4:0] rt, input logic [31:0] rtv,
                       input logic [4:0] rd, input logic we);
    in_valid = 1; in_rs = rs; in_rs_val = rsv; in_rt = rt; in_rt_val = rtv;
    in_rd = rd; in_we = we; in_use_imm = 0; in_imm = 0; in_af = 0; in_i = 0;
    in_is_load = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1; reset = 1;
    step(); step();
    reset = 0; #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_we !== 1'b0) begin fails++; $display("FAIL reset_out_we: got %b want 0", out_we); end
    checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin fails++; $display("FAIL reset_operands: got a=%h b=%h want 0/0", alu_a, alu_b); end
    checks++; if (alu_af !== 4'h0 || alu_i !== 1'b0) begin fails++; $display("FAIL reset_af_i: got af=%h i=%b want 0/0", alu_af, alu_i); end
  endtask

  task automatic test_basic();
    offer(5'd3, 32'd5, 5'd4, 32'd7, 5'd10, 1'b1);
    step();
    in_valid = 0; #1;
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin fails++; $display("FAIL basic_operands: got a=%h b=%h want 5/7", alu_a, alu_b); end
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL basic_handshake: got ov=%b ir=%b want 1/1", out_valid, in_ready); end
    checks++; if (out_we !== 1'b1 || out_rd !== 5'd10) begin fails++; $display("FAIL basic_dest: got we=%b rd=%0d want 1/10", out_we, out_rd); end
    step();
    checks++; if (out_valid !== 1'b0 || out_we !== 1'b0) begin fails++; $display("FAIL basic_drain: got ov=%b we=%b want 0/0", out_valid, out_we); end
  endtask

  task automatic test_forwarding();
    offer(5'd8, 32'h1, 5'd5, 32'h2, 5'd12, 1'b1);
    out_ready = 0;
    step();
    in_valid = 0;
    exmem_we = 1; exmem_rd = 5'd8; exmem_res = 32'h11;
    memwb_we = 1; memwb_rd = 5'd8; memwb_res = 32'h22;
    #1;
    checks++; if (alu_a !== 32'h11) begin fails++; $display("FAIL fwd_exmem_priority: got %h want 11", alu_a); end
    exmem_we = 0; #1;
    checks++; if (alu_a !== 32'h22) begin fails++; $display("FAIL fwd_memwb: got %h want 22", alu_a); end
    exmem_we = 1; exmem_is_load = 1; #1;
    checks++; if (alu_a !== 32'h22 || out_valid !== 1'b0) begin fails++; $display("FAIL fwd_load_not_from_exmem: got a=%h ov=%b want 22/0", alu_a, out_valid); end
    exmem_we = 0; exmem_is_load = 0; memwb_we = 0;
    out_ready = 1;
    offer(5'd0, 32'h77, 5'd0, 32'h66, 5'd13, 1'b1);
    step();
    in_valid = 0; out_ready = 0;
    exmem_we = 1; exmem_rd = 5'd0; exmem_res = 32'h11;
    memwb_we = 1; memwb_rd = 5'd0; memwb_res = 32'h22;
    #1;
    checks++; if (alu_a !== 32'h77 || alu_b !== 32'h66) begin fails++; $display("FAIL fwd_reg0: got a=%h b=%h want 77/66", alu_a, alu_b); end
    idle_inputs(); out_ready = 1;
    step();
  endtask

  task automatic test_load_use();
    offer(5'd1, 32'h3, 5'd9, 32'h5, 5'd14, 1'b1);
    out_ready = 1;
    step();
    offer(5'd2, 32'h4, 5'd3, 32'h6, 5'd15, 1'b1);
    exmem_we = 1; exmem_is_load = 1; exmem_rd = 5'd9; exmem_res = 32'hDEAD;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL loaduse_bubble: got ov=%b ir=%b want 0/0", out_valid, in_ready); end
    checks++; if (out_we !== 1'b0) begin fails++; $display("FAIL loaduse_we_gated: got %b want 0", out_we); end
    step();
    exmem_we = 0; exmem_is_load = 0;
    memwb_we = 1; memwb_rd = 5'd9; memwb_res = 32'hAB;
    #1;
    checks++; if (alu_b !== 32'hAB || out_valid !== 1'b1) begin fails++; $display("FAIL loaduse_resume: got b=%h ov=%b want ab/1", alu_b, out_valid); end
    checks++; if (out_rd !== 5'd14 || in_ready !== 1'b1) begin fails++; $display("FAIL loaduse_held_instr: got rd=%0d ir=%b want 14/1", out_rd, in_ready); end
    step();
    in_valid = 0; memwb_we = 0; #1;
    checks++; if (out_rd !== 5'd15 || out_valid !== 1'b1) begin fails++; $display("FAIL loaduse_next_capture: got rd=%0d ov=%b want 15/1", out_rd, out_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    offer(5'd1, 32'h100, 5'd2, 32'h0, 5'd1, 1'b1);
    out_ready = 0;
    step();
    offer(5'd1, 32'h200, 5'd2, 32'h0, 5'd2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL stall_handshake[%0d]: got ir=%b ov=%b want 0/1", k, in_ready, out_valid); end
      checks++; if (alu_a !== 32'h100 || out_rd !== 5'd1) begin fails++; $display("FAIL stall_frozen[%0d]: got a=%h rd=%0d want 100/1", k, alu_a, out_rd); end
      step();
    end
    out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    step();
    offer(5'd1, 32'h300, 5'd2, 32'h0, 5'd3, 1'b1);
    #1;
    checks++; if (alu_a !== 32'h200 || out_rd !== 5'd2 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_second: got a=%h rd=%0d ov=%b want 200/2/1", alu_a, out_rd, out_valid); end
    step();
    in_valid = 0; #1;
    checks++; if (alu_a !== 32'h300 || out_rd !== 5'd3 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_third: got a=%h rd=%0d ov=%b want 300/3/1", alu_a, out_rd, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    offer(5'd4, 32'h40, 5'd5, 32'h50, 5'd20, 1'b1);
    out_ready = 0;
    step();
    offer(5'd6, 32'h60, 5'd7, 32'h70, 5'd21, 1'b1);
    flush = 1;
    step();
    flush = 0; in_valid = 0; #1;
    checks++; if (out_valid !== 1'b0 || out_we !== 1'b0) begin fails++; $display("FAIL flush_squash: got ov=%b we=%b want 0/0", out_valid, out_we); end
    checks++; if (in_ready !== 1'b1 || out_rd !== 5'd20) begin fails++; $display("FAIL flush_no_capture: got ir=%b rd=%0d want 1/20", in_ready, out_rd); end
    out_ready = 1;
  endtask

  task automatic test_imm();
    offer(5'd2, 32'h0, 5'd6, 32'h1, 5'd22, 1'b1);
    in_use_imm = 1; in_imm = 32'hFFFF_FFF0; in_af = 4'hA; in_i = 1;
    out_ready = 0;
    step();
    in_valid = 0;
    exmem_we = 1; exmem_rd = 5'd6; exmem_res = 32'h33;
    #1;
    checks++; if (alu_b !== 32'hFFFF_FFF0) begin fails++; $display("FAIL imm_alu_b: got %h want fffffff0", alu_b); end
    checks++; if (store_data !== 32'h33) begin fails++; $display("FAIL imm_store_data: got %h want 33", store_data); end
    checks++; if (alu_af !== 4'hA || alu_i !== 1'b1) begin fails++; $display("FAIL imm_af_i: got af=%h i=%b want a/1", alu_af, alu_i); end
    flush = 1; reset = 1;
    step();
    flush = 0; reset = 0; exmem_we = 0; #1;
    checks++; if (out_valid !== 1'b0 || alu_af !== 4'h0) begin fails++; $display("FAIL reset_over_flush: got ov=%b af=%h want 0/0", out_valid, alu_af); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forwarding();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_imm();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
